// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter FSM states, parity helper,
// and the command/response byte values used by the game logic.
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INHIBIT,
        ST_REQ,
        ST_SEND,
        ST_ACK,
        ST_WAIT_IDLE
    } ps2_tx_state_t;

    localparam logic [7:0] CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] CMD_ECHO     = 8'hEE;
    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] RSP_ACK      = 8'hFA;

    // PS/2 frames carry odd parity over the eight data bits.
    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizers for PS2_CLK/PS2_DAT plus a clock falling-edge strobe.
// Ports: clk, rst (sync, active-high), clk_pin/dat_pin (raw pins),
// clk_sync/dat_sync (synchronized levels), clk_fall (one-cycle strobe).
module ps2_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic clk_pin,
    input  logic dat_pin,
    output logic clk_sync,
    output logic dat_sync,
    output logic clk_fall
);

    logic clk_meta;
    logic dat_meta;
    logic clk_prev;

    // Flops reset to 1 because an idle PS/2 bus floats high.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_meta <= 1'b1;
            clk_sync <= 1'b1;
            clk_prev <= 1'b1;
            dat_meta <= 1'b1;
            dat_sync <= 1'b1;
        end else begin
            clk_meta <= clk_pin;
            clk_sync <= clk_meta;
            clk_prev <= clk_sync;
            dat_meta <= dat_pin;
            dat_sync <= dat_meta;
        end
    end

    assign clk_fall = clk_prev & ~clk_sync;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter with request-to-send and ACK check.
// Ports: CLOCK_50, i_rst, i_ps2_clk/i_ps2_dat (raw pins), o_ps2_clk_oe/
// o_ps2_dat_oe (1 = pull low), i_valid/i_data/o_ready, o_busy, o_done, o_err.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int REQ_CYCLES     = 250,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic       CLOCK_50,
    input  logic       i_rst,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_dat,
    output logic       o_ps2_clk_oe,
    output logic       o_ps2_dat_oe,
    input  logic       i_valid,
    input  logic [7:0] i_data,
    output logic       o_ready,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_err
);

    localparam int MAX_A   = (INHIBIT_CYCLES > REQ_CYCLES) ?
                             INHIBIT_CYCLES : REQ_CYCLES;
    localparam int CNT_MAX = (TIMEOUT_CYCLES > MAX_A) ?
                             TIMEOUT_CYCLES : MAX_A;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] REQ_LAST = CNT_W'(REQ_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    ps2_tx_state_t    state;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       idx;
    logic [9:0]       frame;
    logic             clk_oe;
    logic             dat_oe;
    logic             busy;
    logic             done;
    logic             err;

    logic clk_sync;
    logic dat_sync;
    logic clk_fall;
    logic tmo;

    ps2_sync_edge u_sync (
        .clk      (CLOCK_50),
        .rst      (i_rst),
        .clk_pin  (i_ps2_clk),
        .dat_pin  (i_ps2_dat),
        .clk_sync (clk_sync),
        .dat_sync (dat_sync),
        .clk_fall (clk_fall)
    );

    // Counter would hit TIMEOUT_CYCLES on this edge with no device edge seen.
    assign tmo = ~clk_fall & (cnt == TMO_LAST);

    always_ff @(posedge CLOCK_50) begin
        if (i_rst) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            idx    <= '0;
            frame  <= '0;
            clk_oe <= 1'b0;
            dat_oe <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (i_valid) begin
                        // Frame order on the wire: data LSB first, parity, stop.
                        frame  <= {1'b1, odd_parity(i_data), i_data};
                        clk_oe <= 1'b1;
                        dat_oe <= 1'b0;
                        busy   <= 1'b1;
                        cnt    <= '0;
                        state  <= ST_INHIBIT;
                    end
                end
                ST_INHIBIT: begin
                    if (cnt == INH_LAST) begin
                        cnt    <= '0;
                        dat_oe <= 1'b1;
                        state  <= ST_REQ;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                ST_REQ: begin
                    // Start bit stays on data when the clock is handed back.
                    if (cnt == REQ_LAST) begin
                        cnt    <= '0;
                        idx    <= '0;
                        clk_oe <= 1'b0;
                        state  <= ST_SEND;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                ST_SEND, ST_ACK, ST_WAIT_IDLE: begin
                    cnt <= clk_fall ? '0 : cnt + CNT_ONE;
                    if (tmo) begin
                        cnt    <= '0;
                        idx    <= '0;
                        clk_oe <= 1'b0;
                        dat_oe <= 1'b0;
                        busy   <= 1'b0;
                        err    <= 1'b1;
                        state  <= ST_IDLE;
                    end else if (state == ST_SEND) begin
                        if (clk_fall) begin
                            dat_oe <= ~frame[idx];
                            idx    <= idx + 4'd1;
                            if (idx == 4'd9)
                                state <= ST_ACK;
                        end
                    end else if (state == ST_ACK) begin
                        if (clk_fall) begin
                            if (!dat_sync) begin
                                state <= ST_WAIT_IDLE;
                            end else begin
                                cnt    <= '0;
                                idx    <= '0;
                                dat_oe <= 1'b0;
                                busy   <= 1'b0;
                                err    <= 1'b1;
                                state  <= ST_IDLE;
                            end
                        end
                    end else begin
                        if (clk_sync && dat_sync) begin
                            cnt   <= '0;
                            idx   <= '0;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_ps2_clk_oe = clk_oe;
    assign o_ps2_dat_oe = dat_oe;
    assign o_busy       = busy;
    assign o_ready      = ~busy;
    assign o_done       = done;
    assign o_err        = err;

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter: takes one command byte from the game logic (e.g. 8'hED set-LEDs, 8'hFF reset) and sends it to the keyboard using the PS/2 host request-to-send sequence, then checks the device's ACK bit. It pairs with the existing keyboard scan-code receiver on the same PS2_CLK/PS2_DAT pins. The top level builds the open-drain drivers from this block's output enables. While `o_busy` is high, the receiver must ignore the bus.

## Interface
- `INHIBIT_CYCLES`, 5000: clock-low inhibit before request (100 µs at 50 MHz).
- `REQ_CYCLES`, 250: data-low hold with clock still low before clock release (5 µs).
- `TIMEOUT_CYCLES`, 750000: maximum gap between device clock falling edges (15 ms).
- `CLOCK_50` in 1: system clock, 50 MHz.
- `i_rst` in 1: reset, synchronous, active-high.
- `i_ps2_clk` in 1: raw PS2_CLK pin level (asynchronous).
- `i_ps2_dat` in 1: raw PS2_DAT pin level (asynchronous).
- `o_ps2_clk_oe` out 1: 1 pulls PS2_CLK low. 0 releases it (high-Z).
- `o_ps2_dat_oe` out 1: 1 pulls PS2_DAT low. 0 releases it.
- `i_valid` in 1: command byte available.
- `i_data` in 8: command byte.
- `o_ready` out 1: idle, able to accept a command. Equals `~o_busy`.
- `o_busy` out 1: transmission in progress. The receiver is gated off while this is high.
- `o_done` out 1: one-cycle pulse when the device has ACKed and the bus has returned idle.
- `o_err` out 1: one-cycle pulse on a missing ACK or a timeout.

## Operation
- **Input synchronizing:** both pins pass through a 2-FF synchronizer. `fall` = previous synchronized clock & ~current synchronized clock.
- **Accept:** `i_valid & o_ready` latches `i_data` and computes the parity bit as `~^i_data` (odd parity). The FSM goes to INHIBIT. `i_valid` while busy is ignored; there is no queue.
- **States:**
  - **IDLE:** both OEs are 0.
  - **INHIBIT:** `clk_oe`=1 for INHIBIT_CYCLES, then go to REQ.
  - **REQ:** `clk_oe`=1 and `dat_oe`=1 (start bit) for REQ_CYCLES, then go to SEND with `clk_oe`=0. The bit index is set to 0 and the timeout counter is cleared.
  - **SEND:** on each `fall`, drive the next bit. Indices 0–7 are data bits, LSB first. Index 8 is parity. Index 9 is the stop bit (`dat_oe`=0). A bit value of 1 drives `dat_oe`=0; a value of 0 drives `dat_oe`=1. The index increments on each `fall`. After the stop bit is driven, go to ACK.
  - **ACK:** on the next `fall`, sample synchronized data. A value of 0 goes to WAIT_IDLE. A value of 1 pulses `o_err` and goes to IDLE.
  - **WAIT_IDLE:** when synchronized clock and data are both 1, pulse `o_done` and go to IDLE.
- **Timeout:**
  - In SEND, ACK and WAIT_IDLE, the counter clears on every `fall` and otherwise increments.
  - When the counter reaches TIMEOUT_CYCLES, both OEs drop to 0, `o_err` pulses and the FSM goes to IDLE.
- **Reset mid-operation:** on the clock edge where `i_rst` is sampled high, all outputs take their reset values. No `o_done` or `o_err` pulse is emitted. The latched byte is discarded.
- **Reset values:** `o_ps2_clk_oe`=0, `o_ps2_dat_oe`=0, `o_busy`=0, `o_ready`=1, `o_done`=0, `o_err`=0. The FSM is in IDLE and all counters are 0.
- `o_done` and `o_err` are never high in the same cycle. Exactly one of them pulses per accepted command, unless reset intervenes.

## Timing
- **Accept to bus:** `o_busy` and `o_ps2_clk_oe` rise on the cycle after accept.
- **Clock inhibit:** clock low lasts exactly INHIBIT_CYCLES+REQ_CYCLES cycles. Data low starts INHIBIT_CYCLES cycles after `clk_oe` rises.
- **Edge latency:** a pin falling edge to an OE update takes 3 cycles (2 synchronizer stages plus 1 edge register). This is far below the device's ≥30 µs clock-low half period.
- **Release to done:** `o_done` rises 1 cycle after both synchronized lines read high. `o_busy` falls in the same cycle as `o_done` rises.
- **Nominal duration:** 11 device clocks at 10–16.7 kHz, plus 105 µs, gives about 1.2 ms per byte.

## Structure
- **Package `ps2_pkg`:**
  - FSM state enum (IDLE, INHIBIT, REQ, SEND, ACK, WAIT_IDLE).
  - Odd-parity function.
  - Command constants: CMD_SET_LEDS 8'hED, CMD_ECHO 8'hEE, CMD_RESET 8'hFF.
  - Response constant: RSP_ACK 8'hFA.
- **Sub-module `ps2_sync_edge`:** 2-FF synchronizer plus falling-edge detector for one pin. It is instantiated for the clock pin, and its synchronized output also serves the data pin. It is reusable by the receiver.

## Test plan
- **Send 8'hED; device model clocks and ACKs.** Required: clock low for 5000+250 cycles. Bits observed on device rising edges are 1,0,1,1,0,1,1,1, then parity 1, then stop 1. Exactly one `o_done`, `o_err`=0.
- **Send 8'h01.** Required: parity bit 0 (`dat_oe`=1 during index 8). `o_done` pulses once after the model releases both lines.
- **Model leaves data high at the ACK edge.** Required: `o_err` pulses 3 cycles after the 11th falling edge, `o_done` never pulses, both OEs are 0, `o_ready`=1.
- **Model never clocks after request.** Required: `o_err` exactly TIMEOUT_CYCLES cycles after clock release, both OEs released.
- **Accepted 8'hED in progress:**
  - `i_valid` with 8'hFF during the send: required ignored; the wire carries the ED bits only.
  - `i_rst` asserted at data bit 4: required both OEs 0 and `o_busy`=0 the next cycle, no `o_done`/`o_err`. A following 8'hFF then completes normally.
